mmio_input_port: RTL and testbench

//  Read side of the memory-mapped I/O region (addr[8]=1). LEDR/HEX are CPU-written outputs; this block returns board inputs to the CPU.
//  It synchronises the slide switches, debounces the push-buttons and latches button presses.
//  It returns a registered read word for the CPU load path.

---
 rtl/mmio_input_port.sv | 98 +++++++++
 tb/tb_mmio_input_port.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mmio_input_port.sv
// Read side of the MMIO region: synchronised switches, debounced keys with
// write-1-to-clear press latches, and a registered read word for the CPU.
module mmio_input_port #(
    parameter int NKEYS     = 4,
    parameter int NSW       = 10,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      addr,
    input  logic             memwrite,
    input  logic [31:0]      writedata,
    input  logic [NKEYS-1:0] key_n,
    input  logic [NSW-1:0]   sw,
    output logic [31:0]      io_rdata,
    output logic             key_irq
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

    logic [NKEYS-1:0] key_s1, key_s2;
    logic [NSW-1:0]   sw_s1, sw_sync;
    logic [NKEYS-1:0] db_state;
    logic [NKEYS-1:0] press;
    logic [CW-1:0]    cnt [NKEYS];

    logic             io, key_sel, sw_sel;
    logic [NKEYS-1:0] p, flip, rise, clr;
    logic [31:0]      key_word, sw_word;
    logic             unused_bits;

    assign io      = addr[8];
    assign key_sel = io & addr[4];
    assign sw_sel  = io & addr[5];
    assign p       = ~key_s2;
    assign unused_bits = ^{addr, writedata};

    always_comb begin
        flip = '0;
        for (int i = 0; i < NKEYS; i++)
            flip[i] = (p[i] != db_state[i]) && (cnt[i] == CMAX);
    end

    assign rise = flip & p;
    assign clr  = (memwrite & key_sel) ? writedata[8 +: NKEYS] : '0;

    assign key_word = 32'(db_state) | (32'(press) << 8);
    assign sw_word  = 32'(sw_sync);

    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1  <= '1;
            key_s2  <= '1;
            sw_s1   <= '0;
            sw_sync <= '0;
        end else begin
            key_s1  <= key_n;
            key_s2  <= key_s1;
            sw_s1   <= sw;
            sw_sync <= sw_s1;
        end
    end

    // Counter runs only while the synced level disagrees with the debounced one.
    always_ff @(posedge clk) begin
        if (reset) begin
            db_state <= '0;
            for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NKEYS; i++) begin
                if (p[i] == db_state[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    db_state[i] <= p[i];
                    cnt[i]      <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press landing on the same cycle as its clear still wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            press    <= '0;
            io_rdata <= '0;
        end else begin
            press    <= (press & ~clr) | rise;
            io_rdata <= ((key_sel & ~memwrite) ? key_word : 32'h0)
                      | ((sw_sel & ~memwrite) ? sw_word : 32'h0);
        end
    end

    assign key_irq = |press;

endmodule

// File: tb/tb_mmio_input_port.sv
// Directed bench for mmio_input_port with DB_CYCLES=4, NKEYS=4, NSW=10.
module tb_mmio_input_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        memwrite;
    logic [31:0] writedata;
    logic [3:0]  key_n;
    logic [9:0]  sw;
    logic [31:0] io_rdata;
    logic        key_irq;

    int checks = 0;
    int errors = 0;

    mmio_input_port #(
        .NKEYS(4),
        .NSW(10),
        .DB_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .addr(addr),
        .memwrite(memwrite),
        .writedata(writedata),
        .key_n(key_n),
        .sw(sw),
        .io_rdata(io_rdata),
        .key_irq(key_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [31:0] a);
        addr     = a;
        memwrite = 1'b0;
        tick(1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        memwrite  = 1'b1;
        tick(1);
        memwrite  = 1'b0;
        writedata = '0;
    endtask

    initial begin
        reset = 1'b1; addr = '0; memwrite = 1'b0; writedata = '0;
        key_n = 4'hF; sw = '0;

        tick(3);
        chk("rst_rdata", io_rdata, 32'h0);
        reset = 1'b0;
        rd(32'h110);
        chk("rst_key", io_rdata, 32'h0);
        chk("rst_irq", 32'(key_irq), 32'h0);
        rd(32'h120);
        chk("rst_sw", io_rdata, 32'h0);

        sw = 10'h2A5;
        tick(3);
        rd(32'h120);
        chk("sw_read", io_rdata, 32'h2A5);
        rd(32'h130);
        chk("both_sel", io_rdata, 32'h2A5);

        key_n = 4'b1101;
        tick(3);
        key_n = 4'hF;
        tick(10);
        rd(32'h110);
        chk("glitch_key", io_rdata, 32'h0);
        chk("glitch_irq", 32'(key_irq), 32'h0);

        key_n = 4'b1011;
        tick(5);
        rd(32'h110);
        chk("press_early", io_rdata, 32'h0);
        rd(32'h110);
        chk("press_key", io_rdata, 32'h404);
        chk("press_irq", 32'(key_irq), 32'h1);
        key_n = 4'hF;
        tick(8);
        rd(32'h110);
        chk("release_key", io_rdata, 32'h400);
        chk("release_irq", 32'(key_irq), 32'h1);
        rd(32'h110);
        chk("read_no_side", io_rdata, 32'h400);

        wr(32'h110, 32'h400);
        chk("wr_rdata", io_rdata, 32'h0);
        rd(32'h110);
        chk("clear_key", io_rdata, 32'h0);
        chk("clear_irq", 32'(key_irq), 32'h0);

        key_n = 4'b1110;
        tick(5);
        wr(32'h110, 32'h100);
        rd(32'h110);
        chk("set_wins", io_rdata, 32'h101);
        chk("set_wins_irq", 32'(key_irq), 32'h1);
        key_n = 4'hF;
        tick(8);
        wr(32'h110, 32'h100);
        rd(32'h110);
        chk("clear2_key", io_rdata, 32'h0);

        rd(32'h010);
        chk("non_io", io_rdata, 32'h0);
        wr(32'h120, 32'h0);
        chk("wr_sw_zero", io_rdata, 32'h0);
        rd(32'h120);
        chk("sw_again", io_rdata, 32'h2A5);

        key_n = 4'b0111;
        tick(4);
        reset = 1'b1;
        key_n = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(10);
        rd(32'h110);
        chk("rst_mid_key", io_rdata, 32'h0);
        chk("rst_mid_irq", 32'(key_irq), 32'h0);

        key_n = 4'b0111;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        rd(32'h110);
        chk("held_rst_key", io_rdata, 32'h808);
        chk("held_rst_irq", 32'(key_irq), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
